// File: rtl/range_filter_array.sv
// Systolic chain of range-check cells: ranges claim cells in arrival order, IDs sweep all cells
// and are counted at the tail. Optional miss counter: define RANGE_FILTER_MISS_COUNT_EN.
module range_filter_array #(
   parameter int ID_WIDTH    = 49,
   parameter int CELLS       = 200,
   parameter int COUNT_WIDTH = 10
) (
   input  logic                   tck,
   input  logic                   test_logic_reset_n,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic                   in_is_range,
   input  logic [ID_WIDTH-1:0]    in_lo,
   input  logic [ID_WIDTH-1:0]    in_hi,
   output logic [COUNT_WIDTH-1:0] fresh_count,
`ifdef RANGE_FILTER_MISS_COUNT_EN
   output logic [COUNT_WIDTH-1:0] miss_count,
`endif
   output logic                   result_valid,
   output logic                   range_overflow
);

   // Stage k feeds cell k; stage 0 is the input register.
   logic [CELLS-1:0]    st_valid_q, st_valid_d;
   logic [CELLS-1:0]    st_range_q, st_range_d;
   logic [CELLS-1:0]    st_hit_q,   st_hit_d;
   logic [ID_WIDTH-1:0] st_lo_q [CELLS];
   logic [ID_WIDTH-1:0] st_lo_d [CELLS];
   logic [ID_WIDTH-1:0] st_hi_q [CELLS];
   logic [ID_WIDTH-1:0] st_hi_d [CELLS];

   logic [CELLS-1:0]    cell_full_q, cell_full_d;
   logic [ID_WIDTH-1:0] cell_lo_q [CELLS];
   logic [ID_WIDTH-1:0] cell_lo_d [CELLS];
   logic [ID_WIDTH-1:0] cell_hi_q [CELLS];
   logic [ID_WIDTH-1:0] cell_hi_d [CELLS];

   logic [CELLS-1:0]    out_valid, out_hit;

   logic                   tail_valid_q, tail_valid_d;
   logic                   tail_range_q, tail_range_d;
   logic                   tail_hit_q,   tail_hit_d;
   logic [COUNT_WIDTH-1:0] fresh_count_q, fresh_count_d;
   logic                   result_valid_q, result_valid_d;
   logic                   range_overflow_q, range_overflow_d;
`ifdef RANGE_FILTER_MISS_COUNT_EN
   logic [COUNT_WIDTH-1:0] miss_count_q, miss_count_d;
`endif

   always_comb begin
      st_valid_d       = st_valid_q;
      st_range_d       = st_range_q;
      st_hit_d         = st_hit_q;
      st_lo_d          = st_lo_q;
      st_hi_d          = st_hi_q;
      cell_full_d      = cell_full_q;
      cell_lo_d        = cell_lo_q;
      cell_hi_d        = cell_hi_q;
      out_valid        = '0;
      out_hit          = '0;
      fresh_count_d    = fresh_count_q;
      result_valid_d   = 1'b0;
      range_overflow_d = range_overflow_q;
`ifdef RANGE_FILTER_MISS_COUNT_EN
      miss_count_d     = miss_count_q;
`endif

      for (int k = 0; k < CELLS; k++) begin
         out_valid[k] = st_valid_q[k];
         out_hit[k]   = st_hit_q[k] | (~st_range_q[k] & cell_full_q[k] &
                        (cell_lo_q[k] <= st_lo_q[k]) & (st_lo_q[k] <= cell_hi_q[k]));
         // An empty cell consumes the first range that reaches it.
         if (st_valid_q[k] && st_range_q[k] && !cell_full_q[k]) begin
            cell_full_d[k] = 1'b1;
            cell_lo_d[k]   = st_lo_q[k];
            cell_hi_d[k]   = st_hi_q[k];
            out_valid[k]   = 1'b0;
         end
      end

      st_valid_d[0] = in_valid;
      st_range_d[0] = in_is_range;
      st_hit_d[0]   = 1'b0;
      st_lo_d[0]    = in_lo;
      st_hi_d[0]    = in_hi;
      for (int k = 1; k < CELLS; k++) begin
         st_valid_d[k] = out_valid[k-1];
         st_range_d[k] = st_range_q[k-1];
         st_hit_d[k]   = out_hit[k-1];
         st_lo_d[k]    = st_lo_q[k-1];
         st_hi_d[k]    = st_hi_q[k-1];
      end
      tail_valid_d = out_valid[CELLS-1];
      tail_range_d = st_range_q[CELLS-1];
      tail_hit_d   = out_hit[CELLS-1];

      if (tail_valid_q) begin
         if (tail_range_q) begin
            range_overflow_d = 1'b1;
         end else if (tail_hit_q) begin
            result_valid_d = 1'b1;
            if (fresh_count_q != {COUNT_WIDTH{1'b1}}) fresh_count_d = fresh_count_q + 1'b1;
         end else begin
`ifdef RANGE_FILTER_MISS_COUNT_EN
            result_valid_d = 1'b1;
            if (miss_count_q != {COUNT_WIDTH{1'b1}}) miss_count_d = miss_count_q + 1'b1;
`endif
         end
      end

      if (clear) begin
         st_valid_d       = '0;
         st_hit_d         = '0;
         cell_full_d      = '0;
         tail_valid_d     = 1'b0;
         fresh_count_d    = '0;
         result_valid_d   = 1'b0;
         range_overflow_d = 1'b0;
`ifdef RANGE_FILTER_MISS_COUNT_EN
         miss_count_d     = '0;
`endif
      end
   end

   always_ff @(posedge tck or negedge test_logic_reset_n) begin
      if (!test_logic_reset_n) begin
         st_valid_q       <= '0;
         st_range_q       <= '0;
         st_hit_q         <= '0;
         st_lo_q          <= '{default: '0};
         st_hi_q          <= '{default: '0};
         cell_full_q      <= '0;
         cell_lo_q        <= '{default: '0};
         cell_hi_q        <= '{default: '0};
         tail_valid_q     <= 1'b0;
         tail_range_q     <= 1'b0;
         tail_hit_q       <= 1'b0;
         fresh_count_q    <= '0;
         result_valid_q   <= 1'b0;
         range_overflow_q <= 1'b0;
`ifdef RANGE_FILTER_MISS_COUNT_EN
         miss_count_q     <= '0;
`endif
      end else begin
         st_valid_q       <= st_valid_d;
         st_range_q       <= st_range_d;
         st_hit_q         <= st_hit_d;
         st_lo_q          <= st_lo_d;
         st_hi_q          <= st_hi_d;
         cell_full_q      <= cell_full_d;
         cell_lo_q        <= cell_lo_d;
         cell_hi_q        <= cell_hi_d;
         tail_valid_q     <= tail_valid_d;
         tail_range_q     <= tail_range_d;
         tail_hit_q       <= tail_hit_d;
         fresh_count_q    <= fresh_count_d;
         result_valid_q   <= result_valid_d;
         range_overflow_q <= range_overflow_d;
`ifdef RANGE_FILTER_MISS_COUNT_EN
         miss_count_q     <= miss_count_d;
`endif
      end
   end

   assign fresh_count    = fresh_count_q;
   assign result_valid   = result_valid_q;
   assign range_overflow = range_overflow_q;
`ifdef RANGE_FILTER_MISS_COUNT_EN
   assign miss_count     = miss_count_q;
`endif

endmodule
